// File: rtl/axis_boxcar_avg_if.sv
// AXI4-Stream style channel used on both sides of the boxcar averager.
`timescale 1ns/1ps
interface axis_boxcar_avg_if #(
   parameter int DATA_W = 32
);
   // Handshake: a beat moves on a rising edge where tvalid && tready are both
   // high. Once the master raises tvalid it keeps tvalid and tdata steady
   // until that transfer happens, so tvalid never depends on tready. The
   // slave may drive tready from tvalid combinationally.
   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;

   modport master (output tvalid, output tdata, input tready);
   modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_boxcar_avg.sv
// Moving-average (boxcar) filter over the last LENGTH signed samples.
// Stage 1 keeps the circular window and running sum, stage 2 multiplies by
// the fixed-point reciprocal, stage 3 shifts, stage 4 saturates to DATA_W.
// A single stall term freezes every stage while the output is blocked.
`timescale 1ns/1ps
module axis_boxcar_avg #(
   parameter int DATA_W      = 32,
   parameter int LENGTH      = 74,
   parameter int SCALE_MULT  = 14170,
   parameter int SCALE_SHIFT = 20
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   axis_boxcar_avg_if.slave   s_axis,
   axis_boxcar_avg_if.master  m_axis,
   output logic               window_full
);
   localparam int PTR_W  = $clog2(LENGTH);
   localparam int CNT_W  = $clog2(LENGTH + 1);
   localparam int SUM_W  = DATA_W + $clog2(LENGTH) + 1;
   // 17 bits hold the 16-bit unsigned multiplier as a positive signed value.
   localparam int PROD_W = SUM_W + 17;

   localparam logic [PTR_W-1:0]         PTR_LAST = PTR_W'(LENGTH - 1);
   localparam logic [CNT_W-1:0]         CNT_FULL = CNT_W'(LENGTH);
   localparam logic signed [PROD_W-1:0] MULT_EXT = PROD_W'(SCALE_MULT);
   localparam logic signed [PROD_W-1:0] MAX_Q    =
      {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [PROD_W-1:0] MIN_Q    =
      {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   // Window storage is never cleared; cnt_q decides whether a slot is live.
   logic signed [DATA_W-1:0] win_q [LENGTH];

   logic [PTR_W-1:0]         ptr_q, ptr_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic signed [SUM_W-1:0]  sum_q, sum_d;
   logic signed [PROD_W-1:0] sum_ext;
   logic signed [PROD_W-1:0] prod_q, prod_d;
   logic signed [PROD_W-1:0] q_q, q_d;
   logic [DATA_W-1:0]        out_q, out_d;
   logic                     v1_q, v2_q, v3_q, out_valid_q;
   logic                     full_q;

   logic                     stall;
   logic                     accept;
   logic signed [DATA_W-1:0] x;
   logic signed [DATA_W-1:0] old_sample;

   assign x      = s_axis.tdata;
   assign stall  = out_valid_q && !m_axis.tready;
   // A clear cycle refuses input so the sample offered with it is dropped.
   assign s_axis.tready = !stall && !clear;
   assign accept = s_axis.tvalid && s_axis.tready;

   assign m_axis.tvalid = out_valid_q;
   assign m_axis.tdata  = out_q;
   assign window_full   = full_q;

   // Window bookkeeping: the oldest sample leaves the sum only once the window is full.
   always_comb begin
      old_sample = '0;
      sum_d      = sum_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      if (cnt_q == CNT_FULL) begin
         old_sample = win_q[ptr_q];
      end
      if (accept) begin
         sum_d = sum_q + {{(SUM_W-DATA_W){x[DATA_W-1]}}, x}
                       - {{(SUM_W-DATA_W){old_sample[DATA_W-1]}}, old_sample};
         ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
         if (cnt_q != CNT_FULL) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Scaling datapath: signed multiply, floor shift, clamp to the output range.
   always_comb begin
      sum_ext = {{(PROD_W-SUM_W){sum_q[SUM_W-1]}}, sum_q};
      prod_d  = sum_ext * MULT_EXT;
      q_d     = prod_q >>> SCALE_SHIFT;
      out_d   = q_q[DATA_W-1:0];
      if (q_q > MAX_Q) begin
         out_d = {1'b0, {(DATA_W-1){1'b1}}};
      end else if (q_q < MIN_Q) begin
         out_d = {1'b1, {(DATA_W-1){1'b0}}};
      end
   end

   // Sample write into the circular window (no reset needed, masked by cnt_q).
   always_ff @(posedge clk) begin
      if (accept) begin
         win_q[ptr_q] <= x;
      end
   end

   // Pipeline registers: reset/clear empty the pipe, stall freezes all stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q       <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
         full_q      <= 1'b0;
         v1_q        <= 1'b0;
         prod_q      <= '0;
         v2_q        <= 1'b0;
         q_q         <= '0;
         v3_q        <= 1'b0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else if (clear) begin
         sum_q       <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
         full_q      <= 1'b0;
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         v3_q        <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (!stall) begin
         sum_q       <= sum_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         full_q      <= (cnt_d == CNT_FULL);
         v1_q        <= accept;
         prod_q      <= prod_d;
         v2_q        <= v1_q;
         q_q         <= q_d;
         v3_q        <= v2_q;
         out_q       <= out_d;
         out_valid_q <= v3_q;
      end
   end
endmodule

// File: tb/tb_axis_boxcar_avg.sv
// Bench for axis_boxcar_avg: two LENGTH=4 instances (unity and double scale)
// share one stimulus stream; a default-parameter instance covers backpressure.
`timescale 1ns/1ps
module tb_axis_boxcar_avg;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   logic full_a, full_b, full_c;

   int errors = 0;
   int checks = 0;

   longint     hist_ab[$];
   longint     hist_c[$];
   logic [7:0]  exp_a_q[$];
   logic [7:0]  exp_b_q[$];
   logic [31:0] exp_c_q[$];

   logic [7:0]  ea, eb, last_a, last_b;
   logic [31:0] ec, last_c, c_prev_data;
   logic        c_prev_stall = 1'b0;
   logic        bp_active = 1'b0;
   logic        c_done = 1'b0;
   int          in_c = 0;
   int          out_c = 0;

   // Clock and interfaces
   always #5 clk = ~clk;

   axis_boxcar_avg_if #(.DATA_W(8))  s_a ();
   axis_boxcar_avg_if #(.DATA_W(8))  m_a ();
   axis_boxcar_avg_if #(.DATA_W(8))  s_b ();
   axis_boxcar_avg_if #(.DATA_W(8))  m_b ();
   axis_boxcar_avg_if #(.DATA_W(32)) s_c ();
   axis_boxcar_avg_if #(.DATA_W(32)) m_c ();

   assign s_b.tvalid = s_a.tvalid;
   assign s_b.tdata  = s_a.tdata;
   assign m_b.tready = m_a.tready;

   axis_boxcar_avg #(.DATA_W(8), .LENGTH(4), .SCALE_MULT(1), .SCALE_SHIFT(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .s_axis(s_a), .m_axis(m_a), .window_full(full_a));

   axis_boxcar_avg #(.DATA_W(8), .LENGTH(4), .SCALE_MULT(2), .SCALE_SHIFT(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .s_axis(s_b), .m_axis(m_b), .window_full(full_b));

   axis_boxcar_avg dut_c (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .s_axis(s_c), .m_axis(m_c), .window_full(full_c));

   // Reference average: recomputed from the last len samples, zeros before that.
   function automatic longint model_window(input bit use_c, input int len,
                                           input longint mult, input int shift,
                                           input int w);
      longint s, q, hi, lo;
      int     n;
      s = 0;
      n = use_c ? hist_c.size() : hist_ab.size();
      for (int i = 0; i < len && i < n; i++) begin
         s += use_c ? hist_c[n-1-i] : hist_ab[n-1-i];
      end
      q  = (s * mult) >>> shift;
      hi = (longint'(1) <<< (w-1)) - 1;
      lo = -(longint'(1) <<< (w-1));
      if (q > hi) q = hi;
      else if (q < lo) q = lo;
      return q;
   endfunction

   task automatic flush_models();
      hist_ab.delete();
      hist_c.delete();
      exp_a_q.delete();
      exp_b_q.delete();
      exp_c_q.delete();
   endtask

   // Driver: offer one sample to the shared LENGTH=4 stream; called at posedge+1.
   task automatic send_ab(input int x);
      int waited = 0;
      s_a.tvalid = 1'b1;
      s_a.tdata  = 8'(x);
      @(negedge clk);
      while (!s_a.tready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (!s_a.tready) begin
         errors++;
         $display("FAIL send_ab_timeout tready=%b required=1", s_a.tready);
      end else begin
         hist_ab.push_back(longint'(x));
         exp_a_q.push_back(8'(model_window(1'b0, 4, 1, 2, 8)));
         exp_b_q.push_back(8'(model_window(1'b0, 4, 2, 2, 8)));
      end
      @(posedge clk);
      #1;
      s_a.tvalid = 1'b0;
   endtask

   // Driver for the default-parameter instance.
   task automatic send_c(input int x);
      int waited = 0;
      s_c.tvalid = 1'b1;
      s_c.tdata  = 32'(x);
      @(negedge clk);
      while (!s_c.tready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (!s_c.tready) begin
         errors++;
         $display("FAIL send_c_timeout tready=%b required=1", s_c.tready);
      end else begin
         hist_c.push_back(longint'(x));
         exp_c_q.push_back(32'(model_window(1'b1, 74, 14170, 20, 32)));
         in_c++;
      end
      @(posedge clk);
      #1;
      s_c.tvalid = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((exp_a_q.size() != 0 || exp_b_q.size() != 0 || exp_c_q.size() != 0) && n < 500) begin
         @(posedge clk);
         n++;
      end
      #1;
      checks++;
      if (exp_a_q.size() != 0 || exp_b_q.size() != 0 || exp_c_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain pending a=%0d b=%0d c=%0d required=0", tag,
                  exp_a_q.size(), exp_b_q.size(), exp_c_q.size());
      end
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge clk);
      flush_models();
      #1;
      clear = 1'b0;
   endtask

   // Scoreboard: unity-scale instance
   always @(negedge clk) begin
      if (rst_n && m_a.tvalid && m_a.tready) begin
         checks++;
         last_a = m_a.tdata;
         if (exp_a_q.size() == 0) begin
            errors++;
            $display("FAIL out_a_extra got=%0d required=none", $signed(m_a.tdata));
         end else begin
            ea = exp_a_q.pop_front();
            if (m_a.tdata !== ea) begin
               errors++;
               $display("FAIL out_a got=%0d required=%0d", $signed(m_a.tdata), $signed(ea));
            end
         end
      end
   end

   // Scoreboard: double-scale instance
   always @(negedge clk) begin
      if (rst_n && m_b.tvalid && m_b.tready) begin
         checks++;
         last_b = m_b.tdata;
         if (exp_b_q.size() == 0) begin
            errors++;
            $display("FAIL out_b_extra got=%0d required=none", $signed(m_b.tdata));
         end else begin
            eb = exp_b_q.pop_front();
            if (m_b.tdata !== eb) begin
               errors++;
               $display("FAIL out_b got=%0d required=%0d", $signed(m_b.tdata), $signed(eb));
            end
         end
      end
   end

   // Scoreboard and stream-rule monitor: default instance
   always @(negedge clk) begin
      if (rst_n && m_c.tvalid && m_c.tready) begin
         checks++;
         last_c = m_c.tdata;
         if (exp_c_q.size() == 0) begin
            errors++;
            $display("FAIL out_c_extra got=%0d required=none", $signed(m_c.tdata));
         end else begin
            ec = exp_c_q.pop_front();
            if (m_c.tdata !== ec) begin
               errors++;
               $display("FAIL out_c got=%0d required=%0d", $signed(m_c.tdata), $signed(ec));
            end
         end
         if (out_c >= 74) begin
            checks++;
            if ($signed(m_c.tdata) < 999 || $signed(m_c.tdata) > 1001) begin
               errors++;
               $display("FAIL out_c_steady idx=%0d got=%0d required=1000+-1", out_c, $signed(m_c.tdata));
            end
         end
         out_c++;
      end
      if (rst_n && bp_active) begin
         checks++;
         if (s_c.tready !== !(m_c.tvalid && !m_c.tready)) begin
            errors++;
            $display("FAIL tready_rule got=%b required=%b", s_c.tready, !(m_c.tvalid && !m_c.tready));
         end
         if (c_prev_stall) begin
            checks++;
            if (m_c.tvalid !== 1'b1 || m_c.tdata !== c_prev_data) begin
               errors++;
               $display("FAIL stall_hold got=%b/%0d required=1/%0d", m_c.tvalid,
                        $signed(m_c.tdata), $signed(c_prev_data));
            end
         end
         c_prev_stall = m_c.tvalid && !m_c.tready;
         c_prev_data  = m_c.tdata;
      end else begin
         c_prev_stall = 1'b0;
      end
   end

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (m_a.tvalid !== 1'b0 || m_a.tdata !== 8'd0 || full_a !== 1'b0 || s_a.tready !== 1'b1) begin
         errors++;
         $display("FAIL reset_a got v=%b d=%0d f=%b r=%b required v=0 d=0 f=0 r=1",
                  m_a.tvalid, m_a.tdata, full_a, s_a.tready);
      end
      checks++;
      if (m_c.tvalid !== 1'b0 || m_c.tdata !== 32'd0 || full_c !== 1'b0 || s_c.tready !== 1'b1) begin
         errors++;
         $display("FAIL reset_c got v=%b d=%0d f=%b r=%b required v=0 d=0 f=0 r=1",
                  m_c.tvalid, m_c.tdata, full_c, s_c.tready);
      end
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_warmup();
      logic seen;
      m_a.tready = 1'b1;
      send_ab(4);
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (m_a.tvalid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL latency_early got=%b required=0", seen);
      end
      @(negedge clk);
      checks++;
      if (m_a.tvalid !== 1'b1) begin
         errors++;
         $display("FAIL latency_k3 got=%b required=1", m_a.tvalid);
      end
      @(posedge clk);
      #1;
      send_ab(8);
      send_ab(12);
      checks++;
      if (full_a !== 1'b0) begin
         errors++;
         $display("FAIL full_after3 got=%b required=0", full_a);
      end
      send_ab(16);
      checks++;
      if (full_a !== 1'b1) begin
         errors++;
         $display("FAIL full_after4 got=%b required=1", full_a);
      end
      send_ab(20);
      wait_drain("warmup");
      checks++;
      if (last_a !== 8'd14) begin
         errors++;
         $display("FAIL warmup_last got=%0d required=14", $signed(last_a));
      end
   endtask

   task automatic test_neg_floor();
      do_clear();
      send_ab(-3);
      send_ab(0);
      send_ab(0);
      send_ab(0);
      wait_drain("negfloor");
      checks++;
      if (last_a !== 8'hff) begin
         errors++;
         $display("FAIL negfloor_last got=%0d required=-1", $signed(last_a));
      end
      send_ab(0);
      wait_drain("negfloor_zero");
      checks++;
      if (last_a !== 8'd0) begin
         errors++;
         $display("FAIL negfloor_zero got=%0d required=0", $signed(last_a));
      end
   endtask

   task automatic test_saturation();
      do_clear();
      for (int i = 0; i < 4; i++) send_ab(127);
      wait_drain("sat_pos");
      checks++;
      if (last_b !== 8'd127) begin
         errors++;
         $display("FAIL sat_pos got=%0d required=127", $signed(last_b));
      end
      for (int i = 0; i < 4; i++) send_ab(-128);
      wait_drain("sat_neg");
      checks++;
      if (last_b !== 8'h80) begin
         errors++;
         $display("FAIL sat_neg got=%0d required=-128", $signed(last_b));
      end
   endtask

   task automatic test_clear();
      do_clear();
      for (int i = 0; i < 6; i++) send_ab(40);
      checks++;
      if (full_a !== 1'b1) begin
         errors++;
         $display("FAIL clear_pre_full got=%b required=1", full_a);
      end
      clear      = 1'b1;
      s_a.tvalid = 1'b1;
      s_a.tdata  = 8'd99;
      @(negedge clk);
      checks++;
      if (s_a.tready !== 1'b0) begin
         errors++;
         $display("FAIL clear_tready got=%b required=0", s_a.tready);
      end
      @(posedge clk);
      flush_models();
      #1;
      clear      = 1'b0;
      s_a.tvalid = 1'b0;
      @(negedge clk);
      checks++;
      if (m_a.tvalid !== 1'b0 || full_a !== 1'b0) begin
         errors++;
         $display("FAIL clear_state got v=%b f=%b required v=0 f=0", m_a.tvalid, full_a);
      end
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1;
      send_ab(8);
      wait_drain("clear");
      checks++;
      if (last_a !== 8'd2) begin
         errors++;
         $display("FAIL clear_after got=%0d required=2", $signed(last_a));
      end
   endtask

   task automatic test_backpressure();
      in_c      = 0;
      out_c     = 0;
      c_done    = 1'b0;
      bp_active = 1'b1;
      fork
         begin
            for (int i = 0; i < 100; i++) send_c(1000);
            c_done = 1'b1;
         end
         begin
            while (!c_done) begin
               @(posedge clk);
               #1;
               m_c.tready = 1'($urandom_range(0, 1));
            end
         end
      join
      m_c.tready = 1'b1;
      wait_drain("backpressure");
      bp_active = 1'b0;
      checks++;
      if (out_c !== in_c || in_c !== 100) begin
         errors++;
         $display("FAIL bp_count got out=%0d in=%0d required=100", out_c, in_c);
      end
      checks++;
      if (last_c !== 32'd1000) begin
         errors++;
         $display("FAIL bp_last got=%0d required=1000", $signed(last_c));
      end
   endtask

   task automatic test_async_reset();
      do_clear();
      m_a.tready = 1'b0;
      send_ab(4);
      send_ab(8);
      send_ab(12);
      send_ab(16);
      checks++;
      if (m_a.tvalid !== 1'b1) begin
         errors++;
         $display("FAIL rst_pending got=%b required=1", m_a.tvalid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (m_a.tvalid !== 1'b0 || m_a.tdata !== 8'd0 || full_a !== 1'b0 || s_a.tready !== 1'b1) begin
         errors++;
         $display("FAIL rst_async got v=%b d=%0d f=%b r=%b required v=0 d=0 f=0 r=1",
                  m_a.tvalid, m_a.tdata, full_a, s_a.tready);
      end
      flush_models();
      @(negedge clk);
      #1;
      rst_n      = 1'b1;
      m_a.tready = 1'b1;
      @(posedge clk);
      #1;
      send_ab(4);
      send_ab(4);
      wait_drain("rst");
      checks++;
      if (last_a !== 8'd2) begin
         errors++;
         $display("FAIL rst_after got=%0d required=2", $signed(last_a));
      end
   endtask

   // Main sequence
   initial begin
      s_a.tvalid = 1'b0;
      s_a.tdata  = '0;
      m_a.tready = 1'b1;
      s_c.tvalid = 1'b0;
      s_c.tdata  = '0;
      m_c.tready = 1'b1;
      test_reset();
      test_warmup();
      test_neg_floor();
      test_saturation();
      test_clear();
      test_backpressure();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL watchdog time=%0t required=finish earlier", $time);
      $fatal(1);
   end
endmodule

// File: doc/axis_boxcar_avg.md
# axis_boxcar_avg

Parametrised AXI4-Stream moving-average (boxcar) filter in native RTL, the successor to the FIR-compiler-based 74-point averager in the ECG SoC chain. It keeps a circular window of the last `LENGTH` samples and a running sum, and scales the sum by a fixed-point reciprocal. It saturates the result to the output width and supports full `m_axis_tready` backpressure plus a synchronous window clear. It sits between the band-pass FIR and the QRS detection logic.

## Interface
- `DATA_W`, 32, signed sample width for input and output.
- `LENGTH`, 74, window length in samples; legal range 2..1024.
- `SCALE_MULT`, 14170, unsigned reciprocal multiplier (round(2^SCALE_SHIFT / LENGTH)); width 16 bits.
- `SCALE_SHIFT`, 20, arithmetic right shift applied after the multiply.
- `clk` in 1 — sole clock; all logic is rising-edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `clear` in 1 — synchronous window clear (single-cycle pulse).
- `s_axis_tvalid` in 1 — input sample valid.
- `s_axis_tready` out 1 — input can be accepted.
- `s_axis_tdata` in DATA_W — signed input sample.
- `m_axis_tvalid` out 1 — averaged output valid.
- `m_axis_tready` in 1 — downstream ready.
- `m_axis_tdata` out DATA_W — signed, saturated average.
- `window_full` out 1 — high once `LENGTH` samples have been accepted since the last reset or clear.

## Operation
- Storage: register array `buf[0..LENGTH-1]`, write pointer `ptr` (0..LENGTH-1, wraps LENGTH-1→0), fill counter `cnt` (saturates at LENGTH).
- Accept: `s_axis_tvalid && s_axis_tready`.
- On accept:
  - `old = (cnt < LENGTH) ? 0 : buf[ptr]`.
  - `buf[ptr] <= x`.
  - `sum <= sum + x - old`.
  - `ptr` advances, `cnt` increments until it saturates.
- Window semantics: during warm-up, unfilled slots count as zero. Buffer contents are never zeroed; `cnt` masks stale data.
- Sum width: DATA_W + clog2(LENGTH) + 1, signed, so it cannot overflow.
- Stage 2: `prod <= sum * SCALE_MULT`, signed, full width.
- Stage 3: `q = prod >>> SCALE_SHIFT` (floor rounding).
  - `q > 2^(DATA_W-1)-1` → max positive.
  - `q < -2^(DATA_W-1)` → min negative.
  - Otherwise `q` truncates into `m_axis_tdata`.
- Pipeline control: one stall signal, `stall = m_axis_tvalid && !m_axis_tready`.
  - All three stages hold while stalled.
  - `s_axis_tready = !stall`, so it is combinational from `m_axis_tready` and `m_axis_tvalid`.
- `clear`: zeroes `sum`, `ptr`, `cnt`, all stage valids and `m_axis_tvalid` at the next edge. Samples in flight are discarded.
  - Clear has priority over a simultaneous accept; that sample is dropped.
  - `s_axis_tready` is forced low during the `clear` cycle.
- `window_full = (cnt == LENGTH)`, registered.

## Timing
- Reset values:
  - `m_axis_tvalid`=0, `m_axis_tdata`=0, `window_full`=0, `s_axis_tready`=1.
  - Internal: `sum`, `ptr`, `cnt`, `prod` and stage valids are all 0.
- Latency: a sample accepted at edge k produces `m_axis_tvalid`=1 after edge k+3, provided there is no stall.
- Throughput: one sample per cycle while `m_axis_tready`=1.
- AXIS rules:
  - `m_axis_tdata` is stable while `m_axis_tvalid && !m_axis_tready`.
  - `m_axis_tvalid` is never withdrawn without a handshake, except by `clear` or reset.
- Output order: outputs appear strictly in input order, one per accepted input, including warm-up outputs.
- Reset mid-stream: all state returns to its reset value immediately (asynchronously). The first sample after release starts a fresh window.
- Wrap-around: when `ptr` = LENGTH-1, it returns to 0 on accept with no bubble.

## Test plan
- Warm-up and steady state: LENGTH=4, SCALE_MULT=1, SCALE_SHIFT=2, DATA_W=8.
  - Inputs 4, 8, 12, 16, 20 → outputs 1, 3, 6, 10, 14.
  - `window_full` rises after the 4th accept.
  - First output appears 3 cycles after the first accept.
- Negative floor rounding: same config.
  - Inputs -3, 0, 0, 0 → outputs -1, -1, -1, -1 (since -3>>>2 = -1).
  - Then input 0 → output 0.
- Saturation: LENGTH=4, SCALE_MULT=2, SCALE_SHIFT=2, DATA_W=8.
  - Four inputs of 127 → last output 127 (unsaturated value 254).
  - Four inputs of -128 → last output -128.
- Backpressure: default config, constant input 1000 with `m_axis_tready` toggled in a random pattern.
  - No output is lost or duplicated.
  - `m_axis_tdata` stays stable while stalled.
  - `s_axis_tready` is low exactly when `m_axis_tvalid && !m_axis_tready`.
  - Output count equals input count.
  - After 74 inputs, every output equals 1000 (±1 from scaling).
- Clear mid-window: LENGTH=4 config.
  - Feed 40 ×6, pulse `clear` together with a valid sample.
  - That sample is dropped, in-flight outputs vanish, and `window_full`=0.
  - Then feed 8 → output 2.
- Async reset mid-stream: assert `rst_n`=0 for half a cycle while outputs are pending.
  - All outputs drop to reset values immediately.
  - Post-reset inputs 4, 4 → outputs 1, 2.
